// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO: configurable data width, parity and stop bits.
// Frames are serialised back-to-back while the FIFO holds words; the line idles high.
module uart_tx_fifo #(
  parameter int unsigned FPGA_clk_freq = 50000000,
  parameter int unsigned baudrate      = 115200,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_TX_DV,
  input  logic [DATA_BITS-1:0]          i_TX_Byte,
  output logic                          o_TX_Ready,
  output logic                          o_TX_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Active,
  output logic                          o_TX_Done
);

  localparam int unsigned CLKS_PER_BIT = FPGA_clk_freq / baudrate;
  localparam int unsigned STOP_CLKS    = CLKS_PER_BIT * STOP_BITS;
  localparam int unsigned CNT_W        = $clog2(STOP_CLKS + 1);
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W       = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       clk_cnt, clk_cnt_nxt;
  logic [BIT_W-1:0]       bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0]   shreg, shreg_nxt;
  logic                   par_bit, par_bit_nxt;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]      count_nxt;
  logic [DATA_BITS-1:0]   fifo_head;
  logic                   push, pop, fifo_nonempty;
  logic                   serial_c, active_c, done_c;
  logic                   bit_end, stop_end, want_next;

  assign push          = i_TX_DV && o_TX_Ready;
  assign fifo_nonempty = (o_FIFO_Count != '0);
  assign fifo_head     = mem[rd_ptr];
  assign count_nxt     = FCNT_W'(o_FIFO_Count + FCNT_W'(push) - FCNT_W'(pop));

  // FIFO storage; contents need no reset since pointers gate all reads
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_TX_Byte;
  end

  // FIFO pointers, occupancy and write-side status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_FIFO_Count  <= '0;
      o_TX_Ready    <= 1'b1;
      o_TX_Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      o_FIFO_Count  <= count_nxt;
      o_TX_Ready    <= (count_nxt != FCNT_W'(FIFO_DEPTH));
      o_TX_Overflow <= i_TX_DV && !o_TX_Ready;
    end
  end

  // FSM state, datapath and line registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      clk_cnt     <= clk_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shreg       <= shreg_nxt;
      par_bit     <= par_bit_nxt;
      o_TX_Serial <= serial_c;
      o_TX_Active <= active_c;
      o_TX_Done   <= done_c;
    end
  end

  // Next-state and line value; the line register lags the state by one cycle
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    par_bit_nxt = par_bit;
    pop         = 1'b0;
    serial_c    = 1'b1;
    done_c      = 1'b0;
    want_next   = 1'b0;
    active_c    = (state != S_IDLE);
    bit_end     = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    stop_end    = (clk_cnt == CNT_W'(STOP_CLKS - 1));

    case (state)
      S_IDLE: want_next = 1'b1;
      S_START: begin
        serial_c = 1'b0;
        if (bit_end) begin
          clk_cnt_nxt = '0;
          bit_idx_nxt = '0;
          state_nxt   = S_DATA;
        end else begin
          clk_cnt_nxt = CNT_W'(clk_cnt + 1'b1);
        end
      end
      S_DATA: begin
        serial_c = shreg[0];
        if (bit_end) begin
          clk_cnt_nxt = '0;
          shreg_nxt   = shreg >> 1;
          if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
            state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_nxt = BIT_W'(bit_idx + 1'b1);
          end
        end else begin
          clk_cnt_nxt = CNT_W'(clk_cnt + 1'b1);
        end
      end
      S_PARITY: begin
        serial_c = par_bit;
        if (bit_end) begin
          clk_cnt_nxt = '0;
          state_nxt   = S_STOP;
        end else begin
          clk_cnt_nxt = CNT_W'(clk_cnt + 1'b1);
        end
      end
      S_STOP: begin
        if (stop_end) begin
          done_c      = 1'b1;
          clk_cnt_nxt = '0;
          want_next   = 1'b1;
        end else begin
          clk_cnt_nxt = CNT_W'(clk_cnt + 1'b1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Shared frame-boundary pop: straight into START when more words wait
    if (want_next) begin
      if (fifo_nonempty) begin
        pop         = 1'b1;
        shreg_nxt   = fifo_head;
        par_bit_nxt = (^fifo_head) ^ 1'(PARITY == 1);
        clk_cnt_nxt = '0;
        state_nxt   = S_START;
      end else begin
        state_nxt = S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1 framing, parity, 7-bit/2-stop framing,
// back-to-back frames, FIFO overflow and reset mid-frame.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // u0: defaults (8N1, 434 clocks/bit)
  logic       dv0;
  logic [7:0] byte0;
  logic       ready0, ovf0, ser0, act0, done0;
  logic [4:0] cnt0;
  // u1: even parity, u2: odd parity, shared stimulus
  logic       dv1;
  logic [7:0] byte1;
  logic       ready1, ovf1, ser1, act1, done1;
  logic       ready2, ovf2, ser2, act2, done2;
  logic [4:0] cnt1, cnt2;
  // u3: 10 clocks/bit, 7 data bits, 2 stop bits
  logic       dv3;
  logic [6:0] byte3;
  logic       ready3, ovf3, ser3, act3, done3;
  logic [4:0] cnt3;

  uart_tx_fifo u0 (
    .clk(clk), .rst_n(rst_n), .i_TX_DV(dv0), .i_TX_Byte(byte0),
    .o_TX_Ready(ready0), .o_TX_Overflow(ovf0), .o_FIFO_Count(cnt0),
    .o_TX_Serial(ser0), .o_TX_Active(act0), .o_TX_Done(done0)
  );

  uart_tx_fifo #(.PARITY(2)) u1 (
    .clk(clk), .rst_n(rst_n), .i_TX_DV(dv1), .i_TX_Byte(byte1),
    .o_TX_Ready(ready1), .o_TX_Overflow(ovf1), .o_FIFO_Count(cnt1),
    .o_TX_Serial(ser1), .o_TX_Active(act1), .o_TX_Done(done1)
  );

  uart_tx_fifo #(.PARITY(1)) u2 (
    .clk(clk), .rst_n(rst_n), .i_TX_DV(dv1), .i_TX_Byte(byte1),
    .o_TX_Ready(ready2), .o_TX_Overflow(ovf2), .o_FIFO_Count(cnt2),
    .o_TX_Serial(ser2), .o_TX_Active(act2), .o_TX_Done(done2)
  );

  uart_tx_fifo #(.FPGA_clk_freq(1000000), .baudrate(100000), .DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .i_TX_DV(dv3), .i_TX_Byte(byte3),
    .o_TX_Ready(ready3), .o_TX_Overflow(ovf3), .o_FIFO_Count(cnt3),
    .o_TX_Serial(ser3), .o_TX_Active(act3), .o_TX_Done(done3)
  );

  int checks   = 0;
  int failures = 0;
  int el;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, landing 1 time unit after the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance to elapsed cycle t measured from the current frame start
  task automatic goto(input int t);
    if (t > el) tick(t - el);
    el = t;
  endtask

  logic [9:0] exp0, exp3;
  logic [2:0] b0, b7;
  int         done_t [4];
  int         nd, novf, peak;
  logic       drop, bad;

  initial begin
    rst_n = 1'b0;
    dv0 = 1'b0; byte0 = '0;
    dv1 = 1'b0; byte1 = '0;
    dv3 = 1'b0; byte3 = '0;
    exp0 = 10'b1001101110;  // 0x37 8N1, index = bit slot from start
    exp3 = 10'b1110101010;  // 0x55 7N2

    tick(2);
    check("rst_serial",   32'(ser0),   32'd1);
    check("rst_active",   32'(act0),   32'd0);
    check("rst_done",     32'(done0),  32'd0);
    check("rst_overflow", 32'(ovf0),   32'd0);
    check("rst_ready",    32'(ready0), 32'd1);
    check("rst_count",    32'(cnt0),   32'd0);
    rst_n = 1'b1;
    tick(2);

    // 8N1 single frame of 0x37
    dv0 = 1'b1; byte0 = 8'h37;
    tick(1);
    dv0 = 1'b0;
    check("lat_count_after_write", 32'(cnt0), 32'd1);
    tick(1);
    check("lat_line_still_high", 32'(ser0), 32'd1);
    check("lat_count_popped",    32'(cnt0), 32'd0);
    tick(1);
    el = 0;
    check("lat_active", 32'(act0), 32'd1);
    for (int k = 0; k < 10; k++) begin
      goto(k * 434 + 217);
      check($sformatf("frame37_bit%0d", k), 32'(ser0), 32'(exp0[k]));
    end
    goto(4338);
    check("frame37_done_early", 32'(done0), 32'd0);
    goto(4339);
    check("frame37_done",   32'(done0), 32'd1);
    check("frame37_active", 32'(act0),  32'd1);
    goto(4340);
    check("frame37_done_clear", 32'(done0), 32'd0);
    check("frame37_idle",       32'(act0),  32'd0);
    tick(5);

    // Three words on consecutive cycles: contiguous frames
    dv0 = 1'b1; byte0 = 8'h01;
    tick(1);
    byte0 = 8'h80;
    tick(1);
    byte0 = 8'hFF;
    tick(1);
    dv0 = 1'b0;
    check("b2b_count_at_start", 32'(cnt0), 32'd2);
    drop = 1'b0; nd = 0; b0 = '0; b7 = '0;
    for (int e = 0; e < 13020; e++) begin
      if (!act0) drop = 1'b1;
      if (done0) begin
        if (nd < 4) done_t[nd] = e;
        nd++;
      end
      if (e % 4340 == 651)  b0[e / 4340] = ser0;
      if (e % 4340 == 3689) b7[e / 4340] = ser0;
      tick(1);
    end
    check("b2b_active_held", 32'(drop), 32'd0);
    check("b2b_done_count",  32'(nd),   32'd3);
    check("b2b_done0_pos",   32'(done_t[0]), 32'd4339);
    check("b2b_done_gap1",   32'(done_t[1] - done_t[0]), 32'd4340);
    check("b2b_done_gap2",   32'(done_t[2] - done_t[1]), 32'd4340);
    check("b2b_first_bits",  32'(b0), 32'h5);
    check("b2b_last_bits",   32'(b7), 32'h6);
    check("b2b_idle_after",  32'(act0), 32'd0);
    tick(3);

    // Parity: 0x37 even -> 1, odd -> 0, frame 4774 cycles
    dv1 = 1'b1; byte1 = 8'h37;
    tick(1);
    dv1 = 1'b0;
    tick(2);
    el = 0;
    check("par_start_even", 32'(ser1), 32'd0);
    check("par_start_odd",  32'(ser2), 32'd0);
    goto(9 * 434 + 217);
    check("par_bit_even", 32'(ser1), 32'd1);
    check("par_bit_odd",  32'(ser2), 32'd0);
    goto(10 * 434 + 217);
    check("par_stop_even", 32'(ser1), 32'd1);
    goto(4772);
    check("par_done_early", 32'(done1), 32'd0);
    goto(4773);
    check("par_done_even", 32'(done1), 32'd1);
    check("par_done_odd",  32'(done2), 32'd1);
    tick(3);

    // 7 data bits, 2 stop bits, 10 clocks per bit
    dv3 = 1'b1; byte3 = 7'h55;
    tick(1);
    dv3 = 1'b0;
    tick(2);
    el = 0;
    for (int k = 0; k < 10; k++) begin
      goto(k * 10 + 5);
      check($sformatf("f7n2_bit%0d", k), 32'(ser3), 32'(exp3[k]));
    end
    goto(99);
    check("f7n2_done", 32'(done3), 32'd1);
    goto(100);
    check("f7n2_idle", 32'(act3), 32'd0);
    tick(3);

    // 18-cycle write burst into a 16-deep FIFO
    peak = 0; novf = 0;
    dv0 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      byte0 = 8'(i + 16);
      if (i == 16) check("ovf_ready_before_17th", 32'(ready0), 32'd1);
      if (i == 17) check("ovf_ready_low_18th",    32'(ready0), 32'd0);
      tick(1);
      if (ovf0) novf++;
      if (32'(cnt0) > peak) peak = 32'(cnt0);
    end
    dv0 = 1'b0;
    check("ovf_count_full", 32'(cnt0), 32'd16);
    tick(1);
    if (ovf0) novf++;
    check("ovf_pulses",     32'(novf), 32'd1);
    check("ovf_peak_count", 32'(peak), 32'd16);

    // Reset for one cycle mid-DATA with a full queue
    tick(1500);
    check("mid_active_before_rst", 32'(act0), 32'd1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("midrst_line_high", 32'(ser0),   32'd1);
    check("midrst_count",     32'(cnt0),   32'd0);
    check("midrst_active",    32'(act0),   32'd0);
    check("midrst_ready",     32'(ready0), 32'd1);
    bad = 1'b0;
    for (int e = 0; e < 5000; e++) begin
      if (done0 || act0 || !ser0) bad = 1'b1;
      tick(1);
    end
    check("midrst_quiet", 32'(bad), 32'd0);

    dv0 = 1'b1; byte0 = 8'hA5;
    tick(1);
    dv0 = 1'b0;
    tick(2);
    el = 0;
    check("post_rst_start", 32'(ser0), 32'd0);
    goto(651);
    check("post_rst_bit0", 32'(ser0), 32'd1);
    goto(1085);
    check("post_rst_bit1", 32'(ser0), 32'd0);
    goto(4339);
    check("post_rst_done", 32'(done0), 32'd1);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
